// File: rtl/result_batch_collector.sv
// result_batch_collector: captures bfm results into two ping-pong banks of NUM slots and presents full banks.
// Optional idle-timeout partial flush is enabled by defining RBC_FLUSH_TIMEOUT_EN.
module result_batch_collector #(
  parameter int NUM            = 100,
  parameter int RES_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       done_i,
  input  logic [RES_WIDTH-1:0]       res_i,
  output logic                       batch_valid_o,
  input  logic                       batch_ready_i,
  output logic [NUM*RES_WIDTH-1:0]   batch_data_o,
  output logic [$clog2(NUM+1)-1:0]   batch_count_o,
  output logic                       overflow_o,
  output logic [15:0]                drop_cnt_o
);
  localparam int CW = $clog2(NUM+1);
  localparam int DW = NUM*RES_WIDTH;

  typedef enum logic [1:0] {EMPTY = 2'd0, FILLING = 2'd1, FULL = 2'd2} bank_state_e;

  bank_state_e       st_r   [2];
  bank_state_e       st_s   [2];
  logic [DW-1:0]     bank_r [2];
  logic [DW-1:0]     bank_s [2];
  logic [CW-1:0]     cnt_r  [2];
  logic [CW-1:0]     cnt_s  [2];
  logic              fill_sel_r, fill_sel_s;
  logic              rd_sel_r, rd_sel_s;
  logic [CW-1:0]     wr_idx_r, wr_idx_s;
  logic              overflow_s;
  logic [15:0]       drop_cnt_s;
  logic              accept_s;
  logic              valid_s;
  logic [DW-1:0]     data_s;
  logic [CW-1:0]     count_s;

`ifdef RBC_FLUSH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  logic [TW-1:0]     idle_r, idle_s;
`else
  localparam int unused_timeout_c = TIMEOUT_CYCLES;
`endif

  // State register: banks, pointers, counters and the registered output image.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int b = 0; b < 2; b++) begin
        st_r[b]   <= EMPTY;
        bank_r[b] <= {DW{1'b0}};
        cnt_r[b]  <= {CW{1'b0}};
      end
      fill_sel_r    <= 1'b0;
      rd_sel_r      <= 1'b0;
      wr_idx_r      <= {CW{1'b0}};
      overflow_o    <= 1'b0;
      drop_cnt_o    <= 16'h0000;
      batch_valid_o <= 1'b0;
      batch_data_o  <= {DW{1'b0}};
      batch_count_o <= {CW{1'b0}};
`ifdef RBC_FLUSH_TIMEOUT_EN
      idle_r        <= {TW{1'b0}};
`endif
    end else begin
      st_r          <= st_s;
      bank_r        <= bank_s;
      cnt_r         <= cnt_s;
      fill_sel_r    <= fill_sel_s;
      rd_sel_r      <= rd_sel_s;
      wr_idx_r      <= wr_idx_s;
      overflow_o    <= overflow_s;
      drop_cnt_o    <= drop_cnt_s;
      batch_valid_o <= valid_s;
      batch_data_o  <= data_s;
      batch_count_o <= count_s;
`ifdef RBC_FLUSH_TIMEOUT_EN
      idle_r        <= idle_s;
`endif
    end
  end

  // Next-state: accept frees the read bank; capture/drop is judged on pre-edge fill bank state.
  always_comb begin
    st_s       = st_r;
    bank_s     = bank_r;
    cnt_s      = cnt_r;
    fill_sel_s = fill_sel_r;
    wr_idx_s   = wr_idx_r;
    overflow_s = overflow_o;
    drop_cnt_s = drop_cnt_o;
`ifdef RBC_FLUSH_TIMEOUT_EN
    idle_s     = {TW{1'b0}};
`endif
    accept_s   = batch_valid_o & batch_ready_i;
    rd_sel_s   = accept_s ? ~rd_sel_r : rd_sel_r;
    if (accept_s) begin
      st_s[rd_sel_r]   = EMPTY;
      bank_s[rd_sel_r] = {DW{1'b0}};
      cnt_s[rd_sel_r]  = {CW{1'b0}};
    end else begin
      st_s[rd_sel_r]   = st_r[rd_sel_r];
    end

    if (done_i && (st_r[fill_sel_r] == FULL)) begin
      overflow_s = 1'b1;
      drop_cnt_s = (drop_cnt_o == 16'hFFFF) ? drop_cnt_o : drop_cnt_o + 16'd1;
    end else if (done_i) begin
      bank_s[fill_sel_r][wr_idx_r*RES_WIDTH +: RES_WIDTH] = res_i;
      if (wr_idx_r == CW'(NUM-1)) begin
        st_s[fill_sel_r]  = FULL;
        cnt_s[fill_sel_r] = CW'(NUM);
        wr_idx_s          = {CW{1'b0}};
        fill_sel_s        = ~fill_sel_r;
      end else begin
        st_s[fill_sel_r]  = FILLING;
        wr_idx_s          = wr_idx_r + CW'(1'b1);
      end
    end else begin
`ifdef RBC_FLUSH_TIMEOUT_EN
      // A partially filled bank is pushed out once the bfm has been quiet long enough.
      if ((st_r[fill_sel_r] == FILLING) && (idle_r == TW'(TIMEOUT_CYCLES-1))) begin
        st_s[fill_sel_r]  = FULL;
        cnt_s[fill_sel_r] = wr_idx_r;
        wr_idx_s          = {CW{1'b0}};
        fill_sel_s        = ~fill_sel_r;
      end else if (st_r[fill_sel_r] == FILLING) begin
        idle_s            = idle_r + TW'(1'b1);
      end else begin
        idle_s            = {TW{1'b0}};
      end
`else
      wr_idx_s = wr_idx_r;
`endif
    end
  end

  // Output image: what the read bank will hold after this edge.
  always_comb begin
    valid_s = (st_s[rd_sel_s] == FULL);
    data_s  = bank_s[rd_sel_s];
    count_s = cnt_s[rd_sel_s];
  end

endmodule

// File: tb/tb_result_batch_collector.sv
// Bench for result_batch_collector: directed vector table, hand sequences and a queue-based random model.
module tb_result_batch_collector;
  localparam int NUM = 4;
  localparam int W   = 16;
  localparam int TO  = 8;
  localparam int DW  = NUM*W;
  localparam int CW  = $clog2(NUM+1);

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           done = 1'b0;
  logic [W-1:0]   res = '0;
  logic           ready = 1'b0;
  logic           batch_valid;
  logic [DW-1:0]  batch_data;
  logic [CW-1:0]  batch_count;
  logic           overflow;
  logic [15:0]    drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  result_batch_collector #(.NUM(NUM), .RES_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .reset_i(reset), .done_i(done), .res_i(res),
    .batch_valid_o(batch_valid), .batch_ready_i(ready), .batch_data_o(batch_data),
    .batch_count_o(batch_count), .overflow_o(overflow), .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          done;
    logic [W-1:0]  res;
    logic          ready;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    int            exp_count;
    logic          exp_ov;
    int            exp_drops;
  } vec_t;
  vec_t tbl[$];

  typedef struct {
    logic [DW-1:0] data;
    int            cnt;
  } batch_t;
  batch_t        full_q[$];
  logic [DW-1:0] fill_data;
  int            fill_n, idle, m_drops;
  logic          m_ov;

  function automatic void add(input int d, input int r, input int rdy, input int v,
                              input logic [DW-1:0] data, input int cnt, input int ov, input int dc);
    vec_t e;
    e.done = (d != 0); e.res = W'(r); e.ready = (rdy != 0);
    e.exp_valid = (v != 0); e.exp_data = data; e.exp_count = cnt;
    e.exp_ov = (ov != 0); e.exp_drops = dc;
    tbl.push_back(e);
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    full_q.delete();
    fill_data = '0; fill_n = 0; idle = 0; m_ov = 1'b0; m_drops = 0;
  endtask

  task automatic push_full();
    batch_t b;
    b.data = fill_data; b.cnt = fill_n;
    full_q.push_back(b);
    fill_data = '0; fill_n = 0; idle = 0;
  endtask

  // Two banks of storage: a result is lost only when two finished batches are already waiting.
  task automatic model_step(input logic d, input logic [W-1:0] r, input logic rdy);
    bit accept, drop;
    accept = (full_q.size() > 0) && rdy;
    drop   = d && (full_q.size() == 2);
    if (accept) void'(full_q.pop_front());
    if (drop) begin
      m_ov = 1'b1;
      if (m_drops < 65535) m_drops++;
    end else if (d) begin
      fill_data[fill_n*W +: W] = r;
      fill_n++;
      idle = 0;
      if (fill_n == NUM) push_full();
    end
`ifdef RBC_FLUSH_TIMEOUT_EN
    else if (fill_n > 0) begin
      idle++;
      if (idle == TO) push_full();
    end else begin
      idle = 0;
    end
`endif
  endtask

  task automatic cycle(input logic rst, input logic d, input logic [W-1:0] r, input logic rdy);
    reset = rst; done = d; res = r; ready = rdy;
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else model_step(d, r, rdy);
  endtask

  task automatic cmp_model(input string tag);
    check({tag, " valid"}, batch_valid, full_q.size() > 0);
    check({tag, " count"}, batch_count, (full_q.size() > 0) ? full_q[0].cnt : 0);
    if (full_q.size() > 0) check({tag, " data"}, batch_data, full_q[0].data);
    check({tag, " overflow"}, overflow, m_ov);
    check({tag, " drops"}, drop_cnt, m_drops);
  endtask

  initial begin
    // Reset held with done toggling: nothing captured, all outputs zero.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, i[0], W'(i + 5), 1'b1);
      check("reset valid", batch_valid, 0);
      check("reset data", batch_data, 0);
      check("reset count", batch_count, 0);
      check("reset overflow", overflow, 0);
      check("reset drops", drop_cnt, 0);
    end

    // Single batch, then accept.
    add(1, 'h1, 0, 0, 64'h0, 0, 0, 0);
    add(1, 'h2, 0, 0, 64'h0, 0, 0, 0);
    add(1, 'h3, 0, 0, 64'h0, 0, 0, 0);
    add(1, 'h4, 0, 1, 64'h0004_0003_0002_0001, 4, 0, 0);
    add(0, 0,   1, 0, 64'h0, 0, 0, 0);
    // Ping-pong: eight back-to-back, second bank presented with no gap.
    add(1, 'h1, 0, 0, 64'h0, 0, 0, 0);
    add(1, 'h2, 0, 0, 64'h0, 0, 0, 0);
    add(1, 'h3, 0, 0, 64'h0, 0, 0, 0);
    for (int i = 4; i <= 8; i++) add(1, i, 0, 1, 64'h0004_0003_0002_0001, 4, 0, 0);
    add(0, 0, 1, 1, 64'h0008_0007_0006_0005, 4, 0, 0);
    add(0, 0, 1, 0, 64'h0, 0, 0, 0);
    // Overflow: ninth result dropped, overflow stays sticky afterwards.
    for (int i = 1; i <= 3; i++) add(1, 'h10 + i, 0, 0, 64'h0, 0, 0, 0);
    for (int i = 4; i <= 8; i++) add(1, 'h10 + i, 0, 1, 64'h0014_0013_0012_0011, 4, 0, 0);
    add(1, 'h19, 0, 1, 64'h0014_0013_0012_0011, 4, 1, 1);
    add(0, 0,    1, 1, 64'h0018_0017_0016_0015, 4, 1, 1);
    for (int i = 1; i <= 4; i++) add(1, 'h20 + i, 0, 1, 64'h0018_0017_0016_0015, 4, 1, 1);
    add(0, 0, 1, 1, 64'h0024_0023_0022_0021, 4, 1, 1);
    add(0, 0, 1, 0, 64'h0, 0, 1, 1);
    // Accept coinciding with completion; next result captured into the freed bank's slot 0.
    for (int i = 1; i <= 3; i++) add(1, 'h30 + i, 0, 0, 64'h0, 0, 1, 1);
    for (int i = 4; i <= 7; i++) add(1, 'h30 + i, 0, 1, 64'h0034_0033_0032_0031, 4, 1, 1);
    add(1, 'h38, 1, 1, 64'h0038_0037_0036_0035, 4, 1, 1);
    for (int i = 1; i <= 4; i++) add(1, 'h40 + i, 0, 1, 64'h0038_0037_0036_0035, 4, 1, 1);
    // Accept coinciding with a drop: drop judged before the accept frees a bank.
    add(1, 'h99, 1, 1, 64'h0044_0043_0042_0041, 4, 1, 2);
    add(0, 0,    1, 0, 64'h0, 0, 1, 2);

    cycle(1'b1, 1'b0, '0, 1'b0);
    foreach (tbl[i]) begin
      cycle(1'b0, tbl[i].done, tbl[i].res, tbl[i].ready);
      check($sformatf("tbl%0d valid", i), batch_valid, tbl[i].exp_valid);
      check($sformatf("tbl%0d count", i), batch_count, tbl[i].exp_count);
      if (tbl[i].exp_valid) check($sformatf("tbl%0d data", i), batch_data, tbl[i].exp_data);
      check($sformatf("tbl%0d overflow", i), overflow, tbl[i].exp_ov);
      check($sformatf("tbl%0d drops", i), drop_cnt, tbl[i].exp_drops);
    end

    // Reset mid-fill discards the partial batch and clears the sticky overflow.
    cycle(1'b0, 1'b1, 16'h00A0, 1'b0);
    cycle(1'b0, 1'b1, 16'h00B0, 1'b0);
    cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    check("midrst overflow", overflow, 0);
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, W'('hC0 + i), 1'b0);
    check("midrst valid", batch_valid, 1);
    check("midrst data", batch_data, 64'h00C4_00C3_00C2_00C1);
    cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    check("midrst accepted", batch_valid, 0);

`ifdef RBC_FLUSH_TIMEOUT_EN
    // Idle timeout flushes a two-result partial batch after TO quiet cycles.
    cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    cycle(1'b0, 1'b1, 16'h0001, 1'b0);
    cycle(1'b0, 1'b1, 16'h0002, 1'b0);
    for (int k = 1; k <= TO; k++) begin
      cycle(1'b0, 1'b0, 16'h0000, 1'b0);
      check($sformatf("flush idle%0d valid", k), batch_valid, k == TO);
    end
    check("flush count", batch_count, 2);
    check("flush data", batch_data, 64'h0000_0000_0002_0001);
    cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    cycle(1'b0, 1'b1, 16'h0007, 1'b0);
    cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    for (int k = 0; k < TO + 2; k++) cycle(1'b0, 1'b0, 16'h0000, 1'b0);
    check("flush discarded valid", batch_valid, 0);
    check("flush discarded count", batch_count, 0);
`endif

    // Random traffic against the queue model, with varying strobe/ready densities and rare resets.
    cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      int dprob, rprob;
      logic rst_r, d_r, rdy_r;
      dprob = (i / 500) % 3 == 0 ? 90 : ((i / 500) % 3 == 1 ? 40 : 8);
      rprob = (i / 300) % 2 == 0 ? 15 : 60;
      rst_r = ($urandom_range(0, 299) == 0);
      d_r   = ($urandom_range(0, 99) < dprob);
      rdy_r = ($urandom_range(0, 99) < rprob);
      cycle(rst_r, d_r, W'($urandom), rdy_r);
      cmp_model($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
